nh_window_buffer: RTL and testbench

//  Upstream neighbour of the mean-pooling stage. Accepts a raster-order pixel stream.

---
 rtl/nh_window_buffer_pkg.sv | 17 +
 rtl/nh_line_buffer.sv | 46 ++++
 rtl/nh_window_buffer.sv | 179 +++++++++++++++++
 tb/tb_nh_window_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nh_window_buffer_pkg.sv
// Shared constants for the neighbourhood window buffer: FSM encodings, default widths
// and a width helper that never returns zero.
package nh_window_buffer_pkg;

  localparam int NN_BITWIDTH = 31;

  typedef logic [1:0] nh_state_t;

  localparam nh_state_t ST_FILL = 2'd0;
  localparam nh_state_t ST_EMIT = 2'd1;
  localparam nh_state_t ST_LAST = 2'd2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nh_line_buffer.sv
// POOL-1 stored rows, banked by column phase so one read returns a full POOL-wide
// column group of every stored row.
module nh_line_buffer
  import nh_window_buffer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FM_WIDTH = 8,
  parameter int POOL     = 2,
  localparam int GROUPS  = FM_WIDTH / POOL,
  localparam int SLOT_W  = clog2_min1(POOL - 1),
  localparam int PH_W    = clog2_min1(POOL),
  localparam int GRP_W   = clog2_min1(GROUPS),
  localparam int RD_W    = (POOL - 1) * POOL * DATA_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [PH_W-1:0]   wr_phase,
  input  logic [GRP_W-1:0]  wr_group,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [GRP_W-1:0]  rd_group,
  output logic [RD_W-1:0]   rd_data
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < POOL - 1; gi++) begin : g_slot
      for (gj = 0; gj < POOL; gj++) begin : g_bank
        logic [DATA_W-1:0] mem [GROUPS];
        logic [DATA_W-1:0] rd_reg;

        // One bank per (row slot, column phase): a single write and a registered read.
        always_ff @(posedge clock) begin
          if (wr_en && wr_slot == SLOT_W'(gi) && wr_phase == PH_W'(gj))
            mem[wr_group] <= wr_data;
          if (rd_en)
            rd_reg <= mem[rd_group];
        end

        assign rd_data[(gi*POOL + gj)*DATA_W +: DATA_W] = rd_reg;
      end
    end
  endgenerate

endmodule

// File: rtl/nh_window_buffer.sv
// Raster pixel stream to non-overlapping POOL x POOL windows, one flattened window per
// output beat, held in a one-deep output register.
module nh_window_buffer
  import nh_window_buffer_pkg::*;
#(
  parameter int DATA_W    = NN_BITWIDTH + 1,
  parameter int FM_WIDTH  = 8,
  parameter int FM_HEIGHT = 8,
  parameter int POOL      = 2,
  localparam int NH_SIZE  = POOL * POOL
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NH_SIZE*DATA_W-1:0] nh_vector,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_done
);

  localparam int GROUPS = FM_WIDTH / POOL;
  localparam int COL_W  = clog2_min1(FM_WIDTH);
  localparam int ROW_W  = clog2_min1(FM_HEIGHT);
  localparam int PH_W   = clog2_min1(POOL);
  localparam int SLOT_W = clog2_min1(POOL - 1);
  localparam int GRP_W  = clog2_min1(GROUPS);
  localparam int RD_W   = (POOL - 1) * POOL * DATA_W;

  generate
    if (POOL < 2) begin : g_bad_pool
      $error("nh_window_buffer: POOL must be at least 2");
    end
    if (FM_WIDTH % POOL != 0) begin : g_bad_width
      $error("nh_window_buffer: FM_WIDTH must be a multiple of POOL");
    end
    if (FM_HEIGHT % POOL != 0) begin : g_bad_height
      $error("nh_window_buffer: FM_HEIGHT must be a multiple of POOL");
    end
  endgenerate

  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [PH_W-1:0]   col_phase_reg;
  logic [PH_W-1:0]   row_phase_reg;
  logic [GRP_W-1:0]  group_reg;
  nh_state_t         state_reg, state_next;
  logic [DATA_W-1:0] tail_reg [POOL-1];
  logic [NH_SIZE*DATA_W-1:0] nh_vector_reg;
  logic              out_valid_reg;
  logic              frame_done_reg;

  logic accept, consume;
  logic last_row_phase, last_col_phase, col_end, row_end;
  logic complete, final_window, band_end;
  logic [RD_W-1:0]             rd_data;
  logic [(POOL-1)*DATA_W-1:0]  tail_flat;
  logic [NH_SIZE*DATA_W-1:0]   window;

  assign in_ready   = !out_valid_reg || out_ready;
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid_reg && out_ready;
  assign out_valid  = out_valid_reg;
  assign nh_vector  = nh_vector_reg;
  assign frame_done = frame_done_reg;

  assign last_row_phase = (row_phase_reg == PH_W'(POOL - 1));
  assign last_col_phase = (col_phase_reg == PH_W'(POOL - 1));
  assign col_end        = (col_reg == COL_W'(FM_WIDTH - 1));
  assign row_end        = (row_reg == ROW_W'(FM_HEIGHT - 1));
  assign complete       = accept && last_row_phase && last_col_phase;
  assign final_window   = complete && col_end && row_end;
  assign band_end       = complete && col_end && !row_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_reg       <= '0;
      row_reg       <= '0;
      col_phase_reg <= '0;
      row_phase_reg <= '0;
      group_reg     <= '0;
    end else if (accept) begin
      if (col_end) begin
        col_reg       <= '0;
        col_phase_reg <= '0;
        group_reg     <= '0;
        row_reg       <= row_end ? '0 : row_reg + ROW_W'(1);
        row_phase_reg <= last_row_phase ? '0 : row_phase_reg + PH_W'(1);
      end else begin
        col_reg       <= col_reg + COL_W'(1);
        col_phase_reg <= last_col_phase ? '0 : col_phase_reg + PH_W'(1);
        group_reg     <= last_col_phase ? group_reg + GRP_W'(1) : group_reg;
      end
    end
  end

  // The stored rows of a group are fetched when the last band row enters that group,
  // so the registered read is ready by the time the window completes.
  nh_line_buffer #(
    .DATA_W   (DATA_W),
    .FM_WIDTH (FM_WIDTH),
    .POOL     (POOL)
  ) u_line_buffer (
    .clock    (clock),
    .wr_en    (accept && !last_row_phase),
    .wr_slot  (row_phase_reg[SLOT_W-1:0]),
    .wr_phase (col_phase_reg),
    .wr_group (group_reg),
    .wr_data  (in_data),
    .rd_en    (accept && last_row_phase && col_phase_reg == '0),
    .rd_group (group_reg),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clock) begin
    if (accept && last_row_phase) begin
      for (int i = 0; i < POOL - 2; i++)
        tail_reg[i] <= tail_reg[i+1];
      tail_reg[POOL-2] <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < POOL - 1; gi++) begin : g_tail
      assign tail_flat[gi*DATA_W +: DATA_W] = tail_reg[gi];
    end
  endgenerate

  assign window = {in_data, tail_flat, rd_data};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL: begin
        if (final_window)
          state_next = ST_LAST;
        else if (complete && !col_end)
          state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (final_window)
          state_next = ST_LAST;
        else if (band_end)
          state_next = ST_FILL;
      end
      ST_LAST: begin
        if (consume)
          state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_FILL;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= (state_reg == ST_LAST) && consume;
    end
  end

  // A completion wins over a consume in the same cycle, so back-to-back windows never bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nh_vector_reg <= '0;
      out_valid_reg <= 1'b0;
    end else if (complete) begin
      nh_vector_reg <= window;
      out_valid_reg <= 1'b1;
    end else if (consume) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nh_window_buffer.sv
// Directed and randomized-gap checks of nh_window_buffer on a 4x4 and an 8x8 map.
module tb_nh_window_buffer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [31:0]  a_in_data, b_in_data;
  logic         a_in_valid, b_in_valid, a_in_ready, b_in_ready;
  logic [127:0] a_nh, b_nh;
  logic         a_out_valid, b_out_valid, a_out_ready, b_out_ready;
  logic         a_frame_done, b_frame_done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [127:0] a_q[$];
  logic [127:0] b_q[$];
  int a_done = 0;
  int b_done = 0;

  nh_window_buffer #(.DATA_W(32), .FM_WIDTH(4), .FM_HEIGHT(4), .POOL(2)) dut_a (
    .clock(clock), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .nh_vector(a_nh), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .frame_done(a_frame_done)
  );

  nh_window_buffer #(.DATA_W(32), .FM_WIDTH(8), .FM_HEIGHT(8), .POOL(2)) dut_b (
    .clock(clock), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .nh_vector(b_nh), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .frame_done(b_frame_done)
  );

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset) begin
      if (a_out_valid && a_out_ready) a_q.push_back(a_nh);
      if (b_out_valid && b_out_ready) b_q.push_back(b_nh);
      if (a_frame_done) a_done++;
      if (b_frame_done) b_done++;
    end
  end

  function automatic logic [127:0] win(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  // Window w of a 4x4 frame whose pixel values are base + row*4 + col.
  function automatic logic [127:0] exp_a(input int w, input int base);
    int e0;
    e0 = base + 8 * (w / 2) + 2 * (w % 2);
    return win(e0, e0 + 1, e0 + 4, e0 + 5);
  endfunction

  task automatic send_a(input int v);
    int n;
    a_in_data = v;
    a_in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!a_in_ready && n < 1000) begin
      n++;
      @(negedge clock);
    end
    if (!a_in_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_a_timeout pixel %0d: in_ready=0 required 1", v);
    end
    @(posedge clock);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input int v);
    int n;
    b_in_data = v;
    b_in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!b_in_ready && n < 1000) begin
      n++;
      @(negedge clock);
    end
    if (!b_in_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_b_timeout pixel %0d: in_ready=0 required 1", v);
    end
    @(posedge clock);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_in_data = '0;    b_in_data = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b required 1", a_in_ready); end
    tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b required 0", a_out_valid); end
    tests_run++; if (a_nh !== 128'd0) begin tests_failed++; $display("FAIL reset_nh_vector: got %h required 0", a_nh); end
    tests_run++; if (a_frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b required 0", a_frame_done); end
    tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_b_out_valid: got %b required 0", b_out_valid); end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [127:0] exp_w [4];
    exp_w[0] = win(0, 1, 4, 5);
    exp_w[1] = win(2, 3, 6, 7);
    exp_w[2] = win(8, 9, 12, 13);
    exp_w[3] = win(10, 11, 14, 15);
    a_q.delete(); a_done = 0; a_out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      send_a(v);
      if (v == 5) begin
        tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency_valid: got %b required 1", a_out_valid); end
        tests_run++; if (a_nh !== exp_w[0]) begin tests_failed++; $display("FAIL basic_latency_nh: got %h required %h", a_nh, exp_w[0]); end
      end
    end
    drain();
    tests_run++; if (a_q.size() != 4) begin tests_failed++; $display("FAIL basic_count: got %0d required 4", a_q.size()); end
    for (int w = 0; w < 4; w++) begin
      tests_run++; if (a_q[w] !== exp_w[w]) begin tests_failed++; $display("FAIL basic_window%0d: got %h required %h", w, a_q[w], exp_w[w]); end
    end
    tests_run++; if (a_done != 1) begin tests_failed++; $display("FAIL basic_frame_done: got %0d pulses required 1", a_done); end
    $display("[TB] basic: %0d windows collected", a_q.size());
  endtask

  task automatic test_stall;
    a_q.delete(); a_done = 0; a_out_ready = 1'b1;
    for (int v = 0; v < 6; v++) send_a(v);
    a_out_ready = 1'b0;
    a_in_data = 6; a_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_out_valid c%0d: got %b required 1", k, a_out_valid); end
      tests_run++; if (a_nh !== win(0, 1, 4, 5)) begin tests_failed++; $display("FAIL stall_nh c%0d: got %h required %h", k, a_nh, win(0, 1, 4, 5)); end
      tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready c%0d: got %b required 0", k, a_in_ready); end
    end
    @(posedge clock); #1;
    a_out_ready = 1'b1;
    for (int v = 6; v < 16; v++) send_a(v);
    drain();
    tests_run++; if (a_q.size() != 4) begin tests_failed++; $display("FAIL stall_count: got %0d required 4", a_q.size()); end
    for (int w = 0; w < 4; w++) begin
      tests_run++; if (a_q[w] !== exp_a(w, 0)) begin tests_failed++; $display("FAIL stall_window%0d: got %h required %h", w, a_q[w], exp_a(w, 0)); end
    end
    tests_run++; if (a_done != 1) begin tests_failed++; $display("FAIL stall_frame_done: got %0d pulses required 1", a_done); end
    $display("[TB] stall: %0d windows collected", a_q.size());
  endtask

  task automatic test_full_rate;
    int t0;
    a_q.delete(); a_done = 0; a_out_ready = 1'b1;
    t0 = cyc;
    for (int v = 0; v < 16; v++) begin
      send_a(v);
      if (v == 5 || v == 7 || v == 13) begin
        tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL rate_valid_after%0d: got %b required 1", v, a_out_valid); end
      end
      if (v == 6) begin
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rate_valid_after6: got %b required 0", a_out_valid); end
      end
    end
    tests_run++; if (cyc - t0 != 16) begin tests_failed++; $display("FAIL rate_cycles: got %0d required 16", cyc - t0); end
    drain();
    tests_run++; if (a_q.size() != 4) begin tests_failed++; $display("FAIL rate_count: got %0d required 4", a_q.size()); end
    $display("[TB] full_rate: 16 pixels in %0d cycles", cyc - t0);
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1'b1;
    for (int v = 0; v < 7; v++) send_a(v);
    reset = 1'b1;
    #1;
    tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_out_valid: got %b required 0", a_out_valid); end
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_in_ready: got %b required 1", a_in_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    a_q.delete(); a_done = 0;
    for (int v = 0; v < 16; v++) send_a(v);
    drain();
    tests_run++; if (a_q.size() != 4) begin tests_failed++; $display("FAIL midreset_count: got %0d required 4", a_q.size()); end
    for (int w = 0; w < 4; w++) begin
      tests_run++; if (a_q[w] !== exp_a(w, 0)) begin tests_failed++; $display("FAIL midreset_window%0d: got %h required %h", w, a_q[w], exp_a(w, 0)); end
    end
    tests_run++; if (a_done != 1) begin tests_failed++; $display("FAIL midreset_frame_done: got %0d pulses required 1", a_done); end
    $display("[TB] reset_mid: %0d windows collected", a_q.size());
  endtask

  task automatic test_back_to_back;
    a_q.delete(); a_done = 0; a_out_ready = 1'b1;
    for (int v = 0; v < 16; v++) send_a(v);
    for (int v = 0; v < 16; v++) send_a(100 + v);
    drain();
    tests_run++; if (a_q.size() != 8) begin tests_failed++; $display("FAIL b2b_count: got %0d required 8", a_q.size()); end
    tests_run++; if (a_q[4] !== win(100, 101, 104, 105)) begin tests_failed++; $display("FAIL b2b_first_of_frame2: got %h required %h", a_q[4], win(100, 101, 104, 105)); end
    for (int w = 0; w < 8; w++) begin
      tests_run++; if (a_q[w] !== exp_a(w % 4, (w < 4) ? 0 : 100)) begin tests_failed++; $display("FAIL b2b_window%0d: got %h required %h", w, a_q[w], exp_a(w % 4, (w < 4) ? 0 : 100)); end
    end
    tests_run++; if (a_done != 2) begin tests_failed++; $display("FAIL b2b_frame_done: got %0d pulses required 2", a_done); end
    $display("[TB] back_to_back: %0d windows collected", a_q.size());
  endtask

  task automatic test_random;
    logic         done_flag;
    logic         pv, pr;
    logic [127:0] pnh;
    logic [127:0] expw;
    int           e0, k;
    b_q.delete(); b_done = 0;
    done_flag = 1'b0; pv = 1'b0; pr = 1'b0; pnh = '0;
    fork
      begin
        for (int v = 0; v < 64; v++) begin
          k = $urandom_range(0, 2);
          repeat (k) begin @(posedge clock); #1; end
          send_b(v);
        end
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge clock); #1;
          b_out_ready = 1'($urandom_range(0, 1));
        end
        b_out_ready = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(negedge clock);
          if (pv && !pr) begin
            tests_run++; if (b_out_valid !== 1'b1 || b_nh !== pnh) begin tests_failed++; $display("FAIL rand_hold: got valid=%b nh=%h required valid=1 nh=%h", b_out_valid, b_nh, pnh); end
          end
          tests_run++; if (b_in_ready !== (!b_out_valid || b_out_ready)) begin tests_failed++; $display("FAIL rand_in_ready: got %b required %b", b_in_ready, !b_out_valid || b_out_ready); end
          pv = b_out_valid; pr = b_out_ready; pnh = b_nh;
        end
      end
    join
    drain();
    tests_run++; if (b_q.size() != 16) begin tests_failed++; $display("FAIL rand_count: got %0d required 16", b_q.size()); end
    for (int w = 0; w < 16; w++) begin
      e0 = 16 * (w / 4) + 2 * (w % 4);
      expw = win(e0, e0 + 1, e0 + 8, e0 + 9);
      tests_run++; if (b_q[w] !== expw) begin tests_failed++; $display("FAIL rand_window%0d: got %h required %h", w, b_q[w], expw); end
    end
    tests_run++; if (b_done != 1) begin tests_failed++; $display("FAIL rand_frame_done: got %0d pulses required 1", b_done); end
    $display("[TB] random: %0d windows collected", b_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full_rate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
